// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_arbiter
//  Purpose  : Write-side master for the 32x32 register file. Merges execute
//             (A) and load-return (B) results onto the single write port,
//             buffers colliding load returns in a small FIFO and keeps a
//             per-register pending-load scoreboard for decode hazard checks.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             a_valid/a_rd/a_data   - execute result (always accepted)
//             b_valid/b_rd/b_data   - load return, handshake with b_ready
//             pend_set/pend_rd      - load issued, marks rd pending
//             chk_rs1/chk_rs2       - decode sources to check
//             rs1_busy/rs2_busy     - source has an outstanding load
//             rf_addr_rd/rf_data_rd/rf_we - registered register-file write
//             fwd1_hit/fwd2_hit     - write-port forwarding match
//  Config   : WB_FORWARD_EN - when defined, fwd*_hit are live; otherwise 0.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            pend_set,
  input  logic [4:0]      pend_rd,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [4:0]      rf_addr_rd,
  output logic [XLEN-1:0] rf_data_rd,
  output logic            rf_we,
  output logic            fwd1_hit,
  output logic            fwd2_hit
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_fifo_full = FIFO_DEPTH[AW:0];

  // Load-return buffer
  logic [4:0]      r_mem_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_data [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic [31:0]     r_pending;

  logic            w_empty;
  logic            w_full;
  logic            w_b_accept;
  logic            w_pop;
  logic            w_push;
  logic            w_sel_valid;
  logic            w_sel_from_b;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [31:0]     w_pend_set;
  logic [31:0]     w_pend_clr;

  // Occupancy (empty / partial / full) is derived purely from the count.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_fifo_full);
  assign b_ready    = !w_full;
  assign w_b_accept = b_valid && b_ready;

  // The FIFO head only gets the port when execute is idle. An accepted B
  // bypasses the buffer only if nothing older is waiting and A is idle;
  // in every other case it is enqueued (same-cycle push+pop is allowed).
  assign w_pop  = !a_valid && !w_empty;
  assign w_push = w_b_accept && (a_valid || !w_empty);

  // Write-port arbitration: A > FIFO head > bypassed B
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_from_b = 1'b0;
    w_sel_rd     = '0;
    w_sel_data   = '0;
    if (a_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = a_rd;
      w_sel_data  = a_data;
    end else if (!w_empty) begin
      w_sel_valid  = 1'b1;
      w_sel_from_b = 1'b1;
      w_sel_rd     = r_mem_rd[r_rd_ptr];
      w_sel_data   = r_mem_data[r_rd_ptr];
    end else if (w_b_accept) begin
      w_sel_valid  = 1'b1;
      w_sel_from_b = 1'b1;
      w_sel_rd     = b_rd;
      w_sel_data   = b_data;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]   <= b_rd;
      r_mem_data[r_wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scoreboard: a pending bit clears on the same edge that registers the
  // B-sourced write; a new load to the same rd in that cycle wins.
  always_comb begin
    w_pend_set = '0;
    w_pend_clr = '0;
    if (pend_set && (pend_rd != 5'd0)) w_pend_set[pend_rd] = 1'b1;
    if (w_sel_from_b)                  w_pend_clr[w_sel_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
    end
  end

  assign rs1_busy = r_pending[chk_rs1] && (chk_rs1 != 5'd0);
  assign rs2_busy = r_pending[chk_rs2] && (chk_rs2 != 5'd0);

  // Register-file write stage. A slot targeting x0 is consumed with we low.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we      <= 1'b0;
      rf_addr_rd <= '0;
      rf_data_rd <= '0;
    end else begin
      rf_we <= w_sel_valid && (w_sel_rd != 5'd0);
      if (w_sel_valid) begin
        rf_addr_rd <= w_sel_rd;
        rf_data_rd <= w_sel_data;
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd1_hit = rf_we && (rf_addr_rd != 5'd0) && (rf_addr_rd == chk_rs1);
  assign fwd2_hit = rf_we && (rf_addr_rd != 5'd0) && (rf_addr_rd == chk_rs2);
`else
  assign fwd1_hit = 1'b0;
  assign fwd2_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_write_arbiter
//  Purpose  : Directed self-checking bench for wb_write_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        pend_set;
  logic [4:0]  pend_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic        rf_we;
  logic        fwd1_hit;
  logic        fwd2_hit;

  int errors = 0;
  int checks = 0;

  wb_write_arbiter #(.FIFO_DEPTH(4), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .pend_set   (pend_set),
    .pend_rd    (pend_rd),
    .chk_rs1    (chk_rs1),
    .chk_rs2    (chk_rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rf_addr_rd (rf_addr_rd),
    .rf_data_rd (rf_data_rd),
    .rf_we      (rf_we),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid  = 1'b0; a_rd = '0; a_data = '0;
    b_valid  = 1'b0; b_rd = '0; b_data = '0;
    pend_set = 1'b0; pend_rd = '0;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, "_we"},   {31'b0, rf_we}, 32'd1);
    check_eq({tag, "_addr"}, {27'b0, rf_addr_rd}, {27'b0, rd});
    check_eq({tag, "_data"}, rf_data_rd, data);
  endtask

  initial begin
    idle_inputs();
    chk_rs1 = 5'd7;
    chk_rs2 = 5'd3;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_we",    {31'b0, rf_we}, 32'd0);
    check_eq("rst_addr",  {27'b0, rf_addr_rd}, 32'd0);
    check_eq("rst_data",  rf_data_rd, 32'd0);
    check_eq("rst_ready", {31'b0, b_ready}, 32'd1);
    check_eq("rst_busy1", {31'b0, rs1_busy}, 32'd0);
    check_eq("rst_fwd",   {30'b0, fwd1_hit, fwd2_hit}, 32'd0);

    // 1: execute write lands one cycle later
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check_wr("t1", 5'd5, 32'hDEADBEEF);

    // 2: pending load on x7, then its return via bypass clears it
    pend_set = 1'b1; pend_rd = 5'd7;
    tick();
    idle_inputs();
    check_eq("t2_busy_set", {31'b0, rs1_busy}, 32'd1);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h1234;
    #1;
    check_eq("t2_ready", {31'b0, b_ready}, 32'd1);
    tick();
    idle_inputs();
    check_wr("t2", 5'd7, 32'h1234);
    tick();
    check_eq("t2_busy_clr", {31'b0, rs1_busy}, 32'd0);
    check_eq("t2_we_idle",  {31'b0, rf_we}, 32'd0);

    // 3: B collides with A, is buffered, drains when A goes idle
    pend_set = 1'b1; pend_rd = 5'd3;
    tick();
    idle_inputs();
    check_eq("t3_busy2_set", {31'b0, rs2_busy}, 32'd1);
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'hAA;
    tick();
    b_valid = 1'b0;
    check_wr("t3_a1", 5'd1, 32'h11);
    a_rd = 5'd2; a_data = 32'h22;
    tick();
    idle_inputs();
    check_wr("t3_a2", 5'd2, 32'h22);
    check_eq("t3_busy2_buf", {31'b0, rs2_busy}, 32'd1);
    tick();
    check_wr("t3_pop", 5'd3, 32'hAA);
    check_eq("t3_busy2_clr", {31'b0, rs2_busy}, 32'd0);
    tick();
    check_eq("t3_we_idle", {31'b0, rf_we}, 32'd0);

    // 4: fill FIFO under A, hold 5th B, drain in order across pointer wrap
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_rd = 5'(20 + i); a_data = 32'hA0 + 32'(i);
      b_valid = 1'b1; b_rd = 5'(10 + i); b_data = 32'hB0 + 32'(i);
      tick();
      check_wr("t4_a", 5'(20 + i), 32'hA0 + 32'(i));
    end
    check_eq("t4_full_ready", {31'b0, b_ready}, 32'd0);
    b_rd = 5'd14; b_data = 32'hB4;
    a_rd = 5'd24; a_data = 32'hA4;
    tick();
    check_eq("t4_held_ready", {31'b0, b_ready}, 32'd0);
    a_valid = 1'b0;
    tick();                              // head pops, B still refused
    check_wr("t4_d0", 5'd10, 32'hB0);
    check_eq("t4_ready_back", {31'b0, b_ready}, 32'd1);
    tick();                              // pop and push in same cycle
    b_valid = 1'b0;
    check_wr("t4_d1", 5'd11, 32'hB1);
    for (int i = 2; i < 5; i++) begin
      tick();
      check_wr("t4_d", 5'(10 + i), 32'hB0 + 32'(i));
    end
    tick();
    idle_inputs();
    check_eq("t4_empty_we", {31'b0, rf_we}, 32'd0);

    // 5: x0 writes are swallowed; x0 is never pending
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'hFFFF;
    tick();
    idle_inputs();
    check_eq("t5_we", {31'b0, rf_we}, 32'd0);
    check_eq("t5_ready", {31'b0, b_ready}, 32'd1);
    tick();
    check_eq("t5_we2", {31'b0, rf_we}, 32'd0);
    pend_set = 1'b1; pend_rd = 5'd0; chk_rs1 = 5'd0;
    tick();
    idle_inputs();
    check_eq("t5_busy_x0", {31'b0, rs1_busy}, 32'd0);

    // 6: reset with three buffered entries discards them
    pend_set = 1'b1; pend_rd = 5'd15; chk_rs1 = 5'd15;
    tick();
    pend_set = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_rd = 5'd30; a_data = 32'h30;
      b_valid = 1'b1; b_rd = 5'(15 + i); b_data = 32'hC0 + 32'(i);
      tick();
    end
    idle_inputs();
    check_eq("t6_busy_pre", {31'b0, rs1_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_ready", {31'b0, b_ready}, 32'd1);
    check_eq("t6_we",    {31'b0, rf_we}, 32'd0);
    check_eq("t6_busy",  {30'b0, rs1_busy, rs2_busy}, 32'd0);
    tick();
    check_eq("t6_no_drain", {31'b0, rf_we}, 32'd0);

    // Forwarding hit on write port
    a_valid = 1'b1; a_rd = 5'd9; a_data = 32'h99;
    chk_rs1 = 5'd4; chk_rs2 = 5'd9;
    tick();
    idle_inputs();
    check_wr("t6_fw", 5'd9, 32'h99);
`ifdef WB_FORWARD_EN
    check_eq("t6_fwd2", {31'b0, fwd2_hit}, 32'd1);
`else
    check_eq("t6_fwd2", {31'b0, fwd2_hit}, 32'd0);
`endif
    check_eq("t6_fwd1", {31'b0, fwd1_hit}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
